// File: rtl/cast_slice_pipe.sv
// cast_slice_pipe: narrows or widens each lane of a multi-lane bus, with the
// result held in a 2-entry FIFO behind valid/ready handshakes. It also reports
// per-lane clip flags and keeps a saturating count of clipping beats.
module cast_slice_pipe #(
    parameter int IN_W     = 32,
    parameter int OUT_W    = 8,
    parameter int CHANNELS = 2,
    parameter int MODE     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*IN_W-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*OUT_W-1:0] out_data,
    output logic [CHANNELS-1:0]       out_clip,
    input  logic                      clear_count,
    output logic [15:0]               clip_count
);

    logic [CHANNELS*OUT_W-1:0] w_cast;
    logic [CHANNELS-1:0]       w_clip;

    // Per-lane cast. The lanes are independent, so each lane gets its own slice of logic.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic [IN_W-1:0] w_x;
        assign w_x = in_data[k*IN_W +: IN_W];

        if (OUT_W >= IN_W) begin : g_widen
            if (MODE == 2) begin : g_sext
                logic signed [IN_W-1:0] w_xs;
                assign w_xs = w_x;
                assign w_cast[k*OUT_W +: OUT_W] = OUT_W'(w_xs);
            end else begin : g_zext
                assign w_cast[k*OUT_W +: OUT_W] = OUT_W'(w_x);
            end
            assign w_clip[k] = 1'b0;
        end else begin : g_narrow
            logic [OUT_W-1:0] w_lo;
            assign w_lo = w_x[OUT_W-1:0];

            if (MODE == 0) begin : g_trunc
                assign w_cast[k*OUT_W +: OUT_W] = w_lo;
                assign w_clip[k]                = |w_x[IN_W-1:OUT_W];
            end else if (MODE == 1) begin : g_usat
                logic w_over;
                assign w_over                   = |w_x[IN_W-1:OUT_W];
                assign w_cast[k*OUT_W +: OUT_W] = w_over ? {OUT_W{1'b1}} : w_lo;
                assign w_clip[k]                = w_over;
            end else begin : g_ssat
                // The value fits the signed output range only if every bit from
                // the output's sign position upward equals the input's sign bit.
                localparam logic [OUT_W-1:0] L_MIN_NEG = OUT_W'(1) << (OUT_W - 1);
                logic [IN_W-OUT_W:0] w_top;
                logic                w_fits;
                assign w_top  = w_x[IN_W-1:OUT_W-1];
                assign w_fits = (&w_top) | ~(|w_top);
                assign w_cast[k*OUT_W +: OUT_W] = w_fits      ? w_lo :
                                                  w_x[IN_W-1] ? L_MIN_NEG : ~L_MIN_NEG;
                assign w_clip[k] = ~w_fits;
            end
        end
    end

    logic       w_push;
    logic       w_pop;
    logic       w_clip_event;
    logic [1:0] w_count_nxt;

    logic                      r_in_ready;
    logic                      r_out_valid;
    logic [1:0]                r_count;
    logic                      r_wr_ptr;
    logic                      r_rd_ptr;
    logic [CHANNELS*OUT_W-1:0] r_data [2];
    logic [CHANNELS-1:0]       r_clip [2];
    logic [15:0]               r_clip_count;

    assign w_push       = in_valid & r_in_ready;
    assign w_pop        = r_out_valid & out_ready;
    assign w_clip_event = w_push & (|w_clip);

    // Next occupancy from the push/pop pair. A simultaneous push and pop leave it unchanged.
    always_comb begin
        // NOTE: assign the default first so every path drives the signal and no latch is inferred.
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    // Occupancy, pointers and the registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_count     <= 2'd0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt != 2'd2);
            r_out_valid <= (w_count_nxt != 2'd0);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage for the two entries. A write happens only on a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two entries are reset because the head entry drives out_data directly, and out_data must read zero after reset.
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_clip[i] <= '0;
            end
        end else if (w_push) begin
            r_data[r_wr_ptr] <= w_cast;
            r_clip[r_wr_ptr] <= w_clip;
        end
    end

    // Saturating count of clipping pushes. A clear overrides the previous count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clip_count <= 16'd0;
        end else if (clear_count) begin
            r_clip_count <= w_clip_event ? 16'd1 : 16'd0;
        end else if (w_clip_event && (r_clip_count != 16'hFFFF)) begin
            r_clip_count <= r_clip_count + 16'd1;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_data[r_rd_ptr];
    assign out_clip   = r_clip[r_rd_ptr];
    assign clip_count = r_clip_count;

endmodule

// File: tb/tb_cast_slice_pipe.sv
// Bench for cast_slice_pipe. Three instances, one per cast mode, share the
// same stimulus. Each instance is compared against a queue of accepted inputs
// and an arithmetic model of each cast rule.
module tb_cast_slice_pipe;

    localparam int IN_W  = 32;
    localparam int OUT_W = 8;
    localparam int CH    = 2;
    localparam int NM    = 3;
    localparam int DW    = CH * OUT_W;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic clear_count;
    logic [CH*IN_W-1:0] in_data;

    logic          in_ready   [NM];
    logic          out_valid  [NM];
    logic [DW-1:0] out_data   [NM];
    logic [CH-1:0] out_clip   [NM];
    logic [15:0]   clip_count [NM];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NM; g++) begin : g_dut
        cast_slice_pipe #(
            .IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CH), .MODE(g)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid), .in_ready(in_ready[g]), .in_data(in_data),
            .out_valid(out_valid[g]), .out_ready(out_ready),
            .out_data(out_data[g]), .out_clip(out_clip[g]),
            .clear_count(clear_count), .clip_count(clip_count[g])
        );
    end

    logic [CH*IN_W-1:0] q_in [$];
    int exp_cnt [NM];
    int n_cmp = 0;
    int n_bad = 0;

    // One lane cast from the rules, using wide integer arithmetic: {clip, data}
    function automatic logic [8:0] ref_lane(int mode, logic [31:0] x);
        longint u;
        longint s;
        logic [7:0] d;
        logic c;
        u = longint'({32'b0, x});
        s = longint'($signed(x));
        if (mode == 0) begin
            d = 8'(u % 256);
            c = (u > 255);
        end else if (mode == 1) begin
            if (u > 255) begin d = 8'hFF; c = 1'b1; end
            else begin d = 8'(u); c = 1'b0; end
        end else begin
            if (s > 127) begin d = 8'h7F; c = 1'b1; end
            else if (s < -128) begin d = 8'h80; c = 1'b1; end
            else begin d = 8'(s); c = 1'b0; end
        end
        return {c, d};
    endfunction

    function automatic logic [DW+CH-1:0] ref_beat(int mode, logic [CH*IN_W-1:0] din);
        logic [DW-1:0] d;
        logic [CH-1:0] c;
        logic [8:0] l;
        for (int k = 0; k < CH; k++) begin
            l = ref_lane(mode, din[k*IN_W +: IN_W]);
            d[k*OUT_W +: OUT_W] = l[7:0];
            c[k] = l[8];
        end
        return {c, d};
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom % 10)
            0: return 32'd127;
            1: return 32'd128;
            2: return 32'd255;
            3: return 32'd256;
            4: return 32'hFFFF_FF80;
            5: return 32'hFFFF_FF7F;
            6: return $urandom % 256;
            7: return 32'd0;
            8: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Advance one clock and update the model from the handshake rules
    task automatic tick();
        bit push, pop, clipped;
        logic [DW+CH-1:0] b;
        push = in_valid && (q_in.size() < 2);
        pop  = out_ready && (q_in.size() != 0);
        @(posedge clk);
        for (int m = 0; m < NM; m++) begin
            b = ref_beat(m, in_data);
            clipped = |b[DW +: CH];
            if (clear_count) exp_cnt[m] = (push && clipped) ? 1 : 0;
            else if (push && clipped && exp_cnt[m] < 65535) exp_cnt[m]++;
        end
        if (pop) void'(q_in.pop_front());
        if (push) q_in.push_back(in_data);
        #1;
    endtask

    task automatic model_reset();
        q_in.delete();
        for (int m = 0; m < NM; m++) exp_cnt[m] = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear_count = 1'b0; in_data = '0;
        #12;
        for (int r = 0; r < 2; r++) begin
            for (int m = 0; m < NM; m++) begin
                n_cmp++; if (out_valid[m] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid m%0d got %b want 0", m, out_valid[m]); end
                n_cmp++; if (in_ready[m] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready m%0d got %b want 1", m, in_ready[m]); end
                n_cmp++; if (clip_count[m] !== 16'd0) begin n_bad++; $display("FAIL reset_count m%0d got %h want 0", m, clip_count[m]); end
                n_cmp++; if (out_data[m] !== '0 || out_clip[m] !== '0) begin n_bad++; $display("FAIL reset_data m%0d got %h/%b want 0/0", m, out_data[m], out_clip[m]); end
            end
            if (r == 0) begin
                @(negedge clk); rst_n = 1'b1;
                @(posedge clk); #1;
                model_reset();
                repeat (3) tick();
            end
        end
    endtask

    task automatic test_directed();
        logic [CH*IN_W-1:0] vec [NM];
        logic [DW-1:0] want_d [NM];
        logic [CH-1:0] want_c [NM];
        logic [DW+CH-1:0] b;
        vec[0] = {32'h0000_0105, 32'h0000_0005}; want_d[0] = 16'h0505; want_c[0] = 2'b10;
        vec[1] = {32'd200, 32'd300};             want_d[1] = 16'hC8FF; want_c[1] = 2'b01;
        vec[2] = {32'h0000_007F, 32'hFFFF_FF00}; want_d[2] = 16'h7F80; want_c[2] = 2'b01;
        for (int v = 0; v < NM; v++) begin
            in_data = vec[v]; in_valid = 1'b1; out_ready = 1'b0;
            tick();
            in_valid = 1'b0;
            n_cmp++; if (out_valid[v] !== 1'b1) begin n_bad++; $display("FAIL dir_valid m%0d got %b want 1", v, out_valid[v]); end
            n_cmp++; if (out_data[v] !== want_d[v]) begin n_bad++; $display("FAIL dir_data m%0d got %h want %h", v, out_data[v], want_d[v]); end
            n_cmp++; if (out_clip[v] !== want_c[v]) begin n_bad++; $display("FAIL dir_clip m%0d got %b want %b", v, out_clip[v], want_c[v]); end
            if (v == 0) begin
                n_cmp++; if (clip_count[0] !== 16'd1) begin n_bad++; $display("FAIL dir_count m0 got %0d want 1", clip_count[0]); end
            end
            for (int m = 0; m < NM; m++) begin
                b = ref_beat(m, vec[v]);
                n_cmp++; if (out_data[m] !== b[DW-1:0] || out_clip[m] !== b[DW +: CH]) begin
                    n_bad++; $display("FAIL dir_model m%0d v%0d got %h/%b want %h/%b", m, v, out_data[m], out_clip[m], b[DW-1:0], b[DW +: CH]);
                end
                n_cmp++; if (clip_count[m] !== 16'(exp_cnt[m])) begin n_bad++; $display("FAIL dir_cnt m%0d got %0d want %0d", m, clip_count[m], exp_cnt[m]); end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [CH*IN_W-1:0] sent [3];
        logic [DW+CH-1:0] b;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sent[i] = {pick_val(), pick_val()};
            in_data = sent[i];
            for (int m = 0; m < NM; m++) begin
                n_cmp++; if (in_ready[m] !== (i < 2)) begin n_bad++; $display("FAIL bp_in_ready m%0d beat%0d got %b want %b", m, i, in_ready[m], (i < 2)); end
            end
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int m = 0; m < NM; m++) begin
                b = ref_beat(m, sent[0]);
                n_cmp++; if (out_data[m] !== b[DW-1:0] || out_clip[m] !== b[DW +: CH]) begin
                    n_bad++; $display("FAIL bp_hold m%0d got %h/%b want %h/%b", m, out_data[m], out_clip[m], b[DW-1:0], b[DW +: CH]);
                end
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int m = 0; m < NM; m++) begin
                b = ref_beat(m, sent[i]);
                n_cmp++; if (out_valid[m] !== 1'b1 || out_data[m] !== b[DW-1:0] || out_clip[m] !== b[DW +: CH]) begin
                    n_bad++; $display("FAIL bp_order m%0d beat%0d got %b %h/%b want 1 %h/%b", m, i, out_valid[m], out_data[m], out_clip[m], b[DW-1:0], b[DW +: CH]);
                end
            end
            tick();
        end
        for (int m = 0; m < NM; m++) begin
            n_cmp++; if (out_valid[m] !== 1'b0) begin n_bad++; $display("FAIL bp_empty m%0d got %b want 0", m, out_valid[m]); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = {32'hFFFF_0000, 32'h0001_0000};
        tick(); tick();
        in_valid = 1'b0;
        for (int m = 0; m < NM; m++) begin
            n_cmp++; if (in_ready[m] !== 1'b0) begin n_bad++; $display("FAIL mid_full m%0d in_ready got %b want 0", m, in_ready[m]); end
        end
        rst_n = 1'b0;
        #2;
        for (int m = 0; m < NM; m++) begin
            n_cmp++; if (out_valid[m] !== 1'b0 || in_ready[m] !== 1'b1) begin
                n_bad++; $display("FAIL mid_rst_flags m%0d got v=%b r=%b want v=0 r=1", m, out_valid[m], in_ready[m]);
            end
            n_cmp++; if (out_data[m] !== '0 || out_clip[m] !== '0 || clip_count[m] !== 16'd0) begin
                n_bad++; $display("FAIL mid_rst_data m%0d got %h/%b/%0d want 0/0/0", m, out_data[m], out_clip[m], clip_count[m]);
            end
        end
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        logic [31:0] base;
        logic [DW+CH-1:0] b;
        int popped;
        base = $urandom; popped = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            if (i == 100) in_valid = 1'b0;
            else in_data = {base + 32'(2*i + 1), base + 32'(2*i)};
            for (int m = 0; m < NM; m++) begin
                n_cmp++; if (in_ready[m] !== 1'b1) begin n_bad++; $display("FAIL stream_ready m%0d cyc%0d got %b want 1", m, i, in_ready[m]); end
                if (i > 0) begin
                    b = ref_beat(m, q_in[0]);
                    n_cmp++; if (out_valid[m] !== 1'b1 || out_data[m] !== b[DW-1:0] || out_clip[m] !== b[DW +: CH]) begin
                        n_bad++; $display("FAIL stream_beat m%0d cyc%0d got %b %h/%b want 1 %h/%b", m, i, out_valid[m], out_data[m], out_clip[m], b[DW-1:0], b[DW +: CH]);
                    end
                end
            end
            if (out_valid[0] === 1'b1) popped++;
            tick();
        end
        n_cmp++; if (popped != 100) begin n_bad++; $display("FAIL stream_count got %0d want 100", popped); end
        for (int m = 0; m < NM; m++) begin
            n_cmp++; if (out_valid[m] !== 1'b0) begin n_bad++; $display("FAIL stream_drained m%0d got %b want 0", m, out_valid[m]); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [DW+CH-1:0] b;
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom % 4) != 0;
            out_ready   = ($urandom % 3) != 0;
            clear_count = ($urandom % 16) == 0;
            in_data     = {pick_val(), pick_val()};
            for (int m = 0; m < NM; m++) begin
                n_cmp++; if (out_valid[m] !== (q_in.size() != 0) || in_ready[m] !== (q_in.size() < 2)) begin
                    n_bad++; $display("FAIL rand_flags m%0d cyc%0d got v=%b r=%b want occ=%0d", m, i, out_valid[m], in_ready[m], q_in.size());
                end
                n_cmp++; if (clip_count[m] !== 16'(exp_cnt[m])) begin n_bad++; $display("FAIL rand_count m%0d cyc%0d got %0d want %0d", m, i, clip_count[m], exp_cnt[m]); end
                if (q_in.size() != 0) begin
                    b = ref_beat(m, q_in[0]);
                    n_cmp++; if (out_data[m] !== b[DW-1:0] || out_clip[m] !== b[DW +: CH]) begin
                        n_bad++; $display("FAIL rand_beat m%0d cyc%0d got %h/%b want %h/%b", m, i, out_data[m], out_clip[m], b[DW-1:0], b[DW +: CH]);
                    end
                end
            end
            tick();
        end
        in_valid = 1'b0; clear_count = 1'b0; out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
    endtask

    task automatic test_counter();
        in_data = {32'h1234_5678, 32'h8000_0000};
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (65536 + 3) tick();
        for (int m = 0; m < NM; m++) begin
            n_cmp++; if (clip_count[m] !== 16'hFFFF) begin n_bad++; $display("FAIL cnt_sat m%0d got %h want ffff", m, clip_count[m]); end
        end
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0; in_valid = 1'b0;
        for (int m = 0; m < NM; m++) begin
            n_cmp++; if (clip_count[m] !== 16'd1) begin n_bad++; $display("FAIL cnt_clear_push m%0d got %0d want 1", m, clip_count[m]); end
        end
        tick();
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        for (int m = 0; m < NM; m++) begin
            n_cmp++; if (clip_count[m] !== 16'd0) begin n_bad++; $display("FAIL cnt_clear m%0d got %0d want 0", m, clip_count[m]); end
            n_cmp++; if (out_valid[m] !== 1'b0) begin n_bad++; $display("FAIL cnt_drained m%0d got %b want 0", m, out_valid[m]); end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_stream();
        test_random();
        test_counter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
